// File: rtl/axi_burst_checker.sv
// Passive AXI burst monitor: tracks outstanding AW/AR lengths, counts W/R beats,
// and reports handshake-stability, beat-count, last-flag and response-ordering violations.
module axi_burst_checker #(
    parameter int AW     = 32,
    parameter int MAXOUT = 4,
    parameter int CW     = 16
) (
    input  logic                      axi_aclk,
    input  logic                      rst,
    input  logic [AW-1:0]             axi_awaddr,
    input  logic [7:0]                axi_awlen,
    input  logic [2:0]                axi_awsize,
    input  logic [1:0]                axi_awburst,
    input  logic                      axi_awvalid,
    input  logic                      axi_awready,
    input  logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic                      axi_wlast,
    input  logic                      axi_bvalid,
    input  logic                      axi_bready,
    input  logic [1:0]                axi_bresp,
    input  logic [AW-1:0]             axi_araddr,
    input  logic [7:0]                axi_arlen,
    input  logic [2:0]                axi_arsize,
    input  logic [1:0]                axi_arburst,
    input  logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic                      axi_rvalid,
    input  logic                      axi_rready,
    input  logic                      axi_rlast,
    output logic                      err_valid,
    output logic [3:0]                err_code,
    output logic [7:0]                err_flags,
    output logic [CW-1:0]             wr_done,
    output logic [CW-1:0]             rd_done,
    output logic [$clog2(MAXOUT):0]   w_pending
);

    localparam int PW = $clog2(MAXOUT);
    localparam int HW = AW + 13;

    typedef enum logic {
        IDLE,
        BURST
    } beat_state_e;

    // Write-side tracking
    logic [7:0]      w_mem [MAXOUT];
    logic [PW-1:0]   w_wptr_q, w_wptr_d, w_rptr_q, w_rptr_d;
    logic [PW:0]     w_cnt_q, w_cnt_d;
    logic [7:0]      w_beat_q, w_beat_d;
    beat_state_e     w_state_q, w_state_d;
    logic [CW-1:0]   b_owed_q, b_owed_d;
    logic            aw_stall_q, aw_stall_d;
    logic [HW-1:0]   aw_hist_q, aw_hist_d;

    // Read-side tracking
    logic [7:0]      r_mem [MAXOUT];
    logic [PW-1:0]   r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
    logic [PW:0]     r_cnt_q, r_cnt_d;
    logic [7:0]      r_beat_q, r_beat_d;
    beat_state_e     r_state_q, r_state_d;
    logic            ar_stall_q, ar_stall_d;
    logic [HW-1:0]   ar_hist_q, ar_hist_d;

    // Registered outputs
    logic            err_valid_q, err_valid_d;
    logic [3:0]      err_code_q, err_code_d;
    logic [7:0]      err_flags_q, err_flags_d;
    logic [CW-1:0]   wr_done_q, wr_done_d;
    logic [CW-1:0]   rd_done_q, rd_done_d;

    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic            w_empty, w_full, w_act, w_end, w_push;
    logic            r_empty, r_full, r_act, r_end, r_push;
    logic            b_ok;
    logic [7:0]      w_head, r_head;
    logic [HW-1:0]   aw_pay, ar_pay;
    logic [8:1]      viol;

    // Response code carries no protocol meaning for this checker.
    logic            unused_bresp;
    assign unused_bresp = ^axi_bresp;

    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid  & axi_wready;
    assign b_hs  = axi_bvalid  & axi_bready;
    assign ar_hs = axi_arvalid & axi_arready;
    assign r_hs  = axi_rvalid  & axi_rready;

    assign aw_pay = {axi_awaddr, axi_awlen, axi_awsize, axi_awburst};
    assign ar_pay = {axi_araddr, axi_arlen, axi_arsize, axi_arburst};

    // An empty FIFO lets a same-edge address handshake supply the head length.
    assign w_empty = (w_cnt_q == '0);
    assign w_full  = (w_cnt_q == (PW+1)'(MAXOUT));
    assign w_head  = w_empty ? axi_awlen : w_mem[w_rptr_q];
    assign w_act   = w_hs & (!w_empty | aw_hs);
    assign w_end   = w_act & ((w_beat_q == w_head) | axi_wlast);
    assign w_push  = aw_hs & (!w_full | w_end);
    assign b_ok    = b_hs & (b_owed_q != '0);

    assign r_empty = (r_cnt_q == '0);
    assign r_full  = (r_cnt_q == (PW+1)'(MAXOUT));
    assign r_head  = r_empty ? axi_arlen : r_mem[r_rptr_q];
    assign r_act   = r_hs & (!r_empty | ar_hs);
    assign r_end   = r_act & ((r_beat_q == r_head) | axi_rlast);
    assign r_push  = ar_hs & (!r_full | r_end);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_wptr_d    = w_wptr_q + PW'(w_push);
        w_rptr_d    = w_rptr_q + PW'(w_end);
        w_cnt_d     = w_cnt_q + (PW+1)'(w_push) - (PW+1)'(w_end);
        w_beat_d    = w_beat_q;
        w_state_d   = w_state_q;
        b_owed_d    = b_owed_q + CW'(w_end) - CW'(b_ok);
        aw_stall_d  = axi_awvalid & !axi_awready;
        aw_hist_d   = aw_pay;

        r_wptr_d    = r_wptr_q + PW'(r_push);
        r_rptr_d    = r_rptr_q + PW'(r_end);
        r_cnt_d     = r_cnt_q + (PW+1)'(r_push) - (PW+1)'(r_end);
        r_beat_d    = r_beat_q;
        r_state_d   = r_state_q;
        ar_stall_d  = axi_arvalid & !axi_arready;
        ar_hist_d   = ar_pay;

        wr_done_d   = wr_done_q + CW'(b_ok);
        rd_done_d   = rd_done_q + CW'(r_end);

        if (w_end) begin
            w_beat_d = '0;
        end else if (w_act) begin
            w_beat_d = w_beat_q + 8'd1;
        end
        if (r_end) begin
            r_beat_d = '0;
        end else if (r_act) begin
            r_beat_d = r_beat_q + 8'd1;
        end

        case (w_state_q)
            IDLE:    if (w_act && !w_end) w_state_d = BURST;
            BURST:   if (w_end)           w_state_d = IDLE;
            default:                      w_state_d = IDLE;
        endcase
        case (r_state_q)
            IDLE:    if (r_act && !r_end) r_state_d = BURST;
            BURST:   if (r_end)           r_state_d = IDLE;
            default:                      r_state_d = IDLE;
        endcase

        viol[1] = aw_stall_q & (!axi_awvalid | (aw_pay != aw_hist_q));
        viol[2] = w_hs & w_empty & !aw_hs;
        viol[3] = w_act & ((axi_wlast & (w_beat_q < w_head)) |
                           (!axi_wlast & (w_beat_q == w_head)));
        viol[4] = b_hs & (b_owed_q == '0);
        viol[5] = aw_hs & w_full & !w_end;
        viol[6] = r_act & ((axi_rlast & (r_beat_q < r_head)) |
                           (!axi_rlast & (r_beat_q == r_head)));
        viol[7] = r_hs & r_empty & !ar_hs;
        viol[8] = ar_stall_q & (!axi_arvalid | (ar_pay != ar_hist_q));

        err_valid_d = |viol;
        err_flags_d = err_flags_q | viol;
        err_code_d  = 4'd0;
        for (int i = 8; i >= 1; i--) begin
            if (viol[i]) err_code_d = 4'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            w_wptr_q    <= '0;
            w_rptr_q    <= '0;
            w_cnt_q     <= '0;
            w_beat_q    <= '0;
            w_state_q   <= IDLE;
            b_owed_q    <= '0;
            aw_stall_q  <= 1'b0;
            aw_hist_q   <= '0;
            r_wptr_q    <= '0;
            r_rptr_q    <= '0;
            r_cnt_q     <= '0;
            r_beat_q    <= '0;
            r_state_q   <= IDLE;
            ar_stall_q  <= 1'b0;
            ar_hist_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_flags_q <= '0;
            wr_done_q   <= '0;
            rd_done_q   <= '0;
        end else begin
            w_wptr_q    <= w_wptr_d;
            w_rptr_q    <= w_rptr_d;
            w_cnt_q     <= w_cnt_d;
            w_beat_q    <= w_beat_d;
            w_state_q   <= w_state_d;
            b_owed_q    <= b_owed_d;
            aw_stall_q  <= aw_stall_d;
            aw_hist_q   <= aw_hist_d;
            r_wptr_q    <= r_wptr_d;
            r_rptr_q    <= r_rptr_d;
            r_cnt_q     <= r_cnt_d;
            r_beat_q    <= r_beat_d;
            r_state_q   <= r_state_d;
            ar_stall_q  <= ar_stall_d;
            ar_hist_q   <= ar_hist_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_flags_q <= err_flags_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

    // NOTE: FIFO storage is not reset; the cleared pointers and counts make stale entries unreachable.
    always_ff @(posedge axi_aclk) begin
        if (w_push) w_mem[w_wptr_q] <= axi_awlen;
        if (r_push) r_mem[r_wptr_q] <= axi_arlen;
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_flags = err_flags_q;
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;
    assign w_pending = w_cnt_q;

endmodule

// File: doc/axi_burst_checker.md
# axi_burst_checker

Passive protocol monitor placed directly downstream of the AXI protocol FSM. It consumes the generated `axi_*` AW/W/B/AR/R channel signals and drives no bus signals. It tracks outstanding bursts and counts beats against `awlen`/`arlen`. It reports handshake-stability, beat-count, last-flag and response-ordering violations as error pulses, sticky flags and completion counters for formal and simulation benches.

## Interface
- `AW`, default 32: address width.
- `MAXOUT`, default 4: depth of each outstanding-burst length FIFO (power of 2, ≥2).
- `CW`, default 16: width of the completion counters.
- `axi_aclk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `axi_awaddr`/`axi_awlen`/`axi_awsize`/`axi_awburst`  in  AW/8/3/2  write address payload.
- `axi_awvalid`, `axi_awready`  in  1 each  AW handshake.
- `axi_wvalid`, `axi_wready`, `axi_wlast`  in  1 each  W handshake and last flag.
- `axi_bvalid`, `axi_bready`  in  1 each  B handshake.
- `axi_bresp`  in  2  write response.
- `axi_araddr`/`axi_arlen`/`axi_arsize`/`axi_arburst`  in  AW/8/3/2  read address payload.
- `axi_arvalid`, `axi_arready`  in  1 each  AR handshake.
- `axi_rvalid`, `axi_rready`, `axi_rlast`  in  1 each  R handshake and last flag.
- `err_valid`  out  1  one-cycle pulse: at least one violation was detected on the previous edge.
- `err_code`  out  4  lowest-numbered violation of that cycle; 0 when `err_valid`=0.
- `err_flags`  out  8  sticky; bit i-1 is set by code i.
- `wr_done`, `rd_done`  out  CW each  completed write bursts (B handshakes) and completed read bursts.
- `w_pending`  out  $clog2(MAXOUT)+1  AW accepted but W burst not yet finished.

## Operation
- A handshake on channel X occurs on an edge where `X_valid` and `X_ready` are both 1.
- Write length FIFO:
  - An AW handshake pushes `axi_awlen`.
  - A W burst ends at the beat where `w_beat == head_len` or `axi_wlast`=1, whichever comes first.
  - At burst end the FIFO pops, `w_beat` returns to 0 and `b_owed` increments. Otherwise each W beat increments `w_beat`.
- Bypass: when the FIFO is empty and an AW and a W handshake occur on the same edge, the W beat counts against the awlen being pushed.
- Per-channel beat FSM (W and R, independently):
  - IDLE → BURST on the first beat of a burst with len>0.
  - BURST → IDLE at burst end.
  - A len=0 burst stays in IDLE and completes on its single beat.
- B tracking:
  - A B handshake with `b_owed`=0 raises code 4; `b_owed` does not go negative.
  - Otherwise `b_owed` decrements and `wr_done` increments.
  - A B handshake on the same edge as the final W beat counts as `b_owed`=0, so it is code 4. B must follow at least 1 cycle after the final W beat.
- The read side mirrors the write side using `axi_arlen`, R beats and `axi_rlast`. `rd_done` increments at each R burst end. There is no response channel on the read side.
- Violation codes:
  - 1: AW stability. The previous edge had `awvalid`=1 and `awready`=0, and now `awvalid` dropped or addr/len/size/burst changed.
  - 2: W beat with the write FIFO empty and no bypass.
  - 3: `wlast` mismatch, i.e. `wlast`=1 with `w_beat<len`, or `wlast`=0 with `w_beat==len`.
  - 4: B with nothing owed.
  - 5: AW handshake with the write FIFO full. The entry is dropped.
  - 6: `rlast` mismatch.
  - 7: R beat with the read FIFO empty and no bypass.
  - 8: AR stability, same rule as code 1.
- Recovery after a violation:
  - Code 2/7 beats are ignored.
  - A code 3/6 burst still terminates per the burst-end rule, so the checker resynchronises.
- `axi_bresp` ≠ 0 is not a violation.
- Counters wrap modulo 2^CW.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - All outputs are 0.
  - FIFOs are empty; `w_beat`, `r_beat` and `b_owed` are 0; both FSMs are IDLE.
  - The stability history registers are cleared, so the first post-reset cycle never raises code 1 or 8.
- `rst` mid-burst discards all tracking state with no error report.
- All outputs are registered:
  - Events on edge N appear on `err_*` and the counters after edge N+1.
  - `err_valid` is never high for two cycles unless violations occur on consecutive edges.
- FIFO push and pop on the same edge are both legal:
  - Full with a simultaneous pop and push is not an overflow.
  - `w_pending` is unchanged in that case.

## Test plan
- AW len=3, then 4 W beats with `wlast` on beat 4, then B 2 cycles later → no error; `wr_done`=1; `w_pending` goes 1→0 after beat 4.
- AW len=2, then `wlast`=1 on beat 2 → `err_code`=3 for one cycle, `err_flags`=0x04. The following AW len=0 burst with one `wlast` beat completes cleanly.
- `awvalid`=1 and `awready`=0 for 2 cycles with `awaddr` changed 0x100→0x104 → `err_code`=1.
- MAXOUT=4: 5 AW handshakes with no W traffic → fifth raises code 5; `w_pending`=4.
- B handshake on the same edge as the final W beat → code 4; `wr_done` unchanged.
- Same edge: R beat with the read FIFO empty and no AR (code 7) plus a W beat with no AW (code 2) → `err_code`=2, `err_flags`=0x42.
